cache_response_router: RTL
==========================

# cache_response_router

Sits directly downstream of the cache request generator. Consumes in-order read responses returned by the cache and routes each response back to the memory requestor that issued the matching request. Requestor IDs are recorded at issue time in an in-order ID FIFO. Response data passes through a 2-entry output buffer, so the ready signal to the cache is registered and throughput is one response per cycle.

## Interface

Parameters:
- `NUM_MEMORY_REQUESTOR`, default 2: number of requestors served.
- `ID_WIDTH`, default `$clog2(NUM_MEMORY_REQUESTOR)` (minimum 1): width of a requestor ID.
- `DATA_WIDTH`, default 512: width of a cache response data word.
- `ID_FIFO_DEPTH`, default 16: power of two; must be ≥ the outstanding limit of the request generator.
- `COUNT_WIDTH`, default `$clog2(ID_FIFO_DEPTH+1)`: width of the outstanding count.

Ports:
- `ap_clk` in 1: clock. One clock domain; all logic on the rising edge.
- `ap_rst_n` in 1: reset, synchronous, active-low.
- `req_issue_valid` in 1: single-cycle pulse; a request was sent to the cache.
- `req_issue_id` in `ID_WIDTH`: requestor index of that request.
- `cache_resp_valid` in 1: cache response valid.
- `cache_resp_rdata` in `DATA_WIDTH`: cache response data.
- `cache_resp_ready` out 1: router can accept a response.
- `mem_resp_valid` out `NUM_MEMORY_REQUESTOR`: one-hot; set bit is the head entry's requestor.
- `mem_resp_data` out `DATA_WIDTH`: head entry data, shared by all requestors.
- `mem_resp_ready` in `NUM_MEMORY_REQUESTOR`: per-requestor accept.
- `outstanding_count` out `COUNT_WIDTH`: ID FIFO occupancy.
- `id_fifo_full` out 1: ID FIFO full.
- `id_fifo_empty` out 1: ID FIFO empty.
- `issue_overflow_error` out 1: sticky error flag.
- `resp_orphan_error` out 1: sticky error flag.

## Operation

ID FIFO:
- Depth `ID_FIFO_DEPTH`.
- Push `req_issue_id` when `req_issue_valid` is high.
- Pop on each accepted response (accept = `cache_resp_valid & cache_resp_ready`).
- Push and pop in the same cycle: occupancy unchanged. Valid even when full, because the pop frees the slot first.
- Push while full with no simultaneous pop: the ID is dropped and `issue_overflow_error` is set.
- Pointers wrap modulo the depth.
- `id_fifo_full`, `id_fifo_empty` and `outstanding_count` are registered and reflect the post-edge occupancy.

Output buffer:
- 2 entries, each holding {id, data}, in order. Occupancy `occ` is 0..2.
- On accept, the pair {popped FIFO head ID, `cache_resp_rdata`} is written at the buffer tail.
- The head entry drives `mem_resp_data` and sets bit `mem_resp_valid[head_id]`; all other bits are 0. `mem_resp_valid` is all-zero when `occ` is 0.
- The head drains when `mem_resp_ready[head_id]` is high. Ready bits of other requestors are ignored.
- Strict in-order delivery: a stalled head blocks the second entry (head-of-line blocking by design).
- Accept and drain in the same cycle are both allowed; `occ` is unchanged.

Ready generation:
- `ready_q` is a register, loaded every cycle with (`occ_next` < 2).
- `cache_resp_ready = ready_q & ~id_fifo_empty`.
- At most one accept per cycle, so `occ` never exceeds 2.

Orphan response:
- Condition: `cache_resp_valid` high while `id_fifo_empty` is high and the cache ignores ready.
- Nothing is written; `resp_orphan_error` is set. This is only reachable when the cache violates the handshake. Detection uses `cache_resp_valid & ready_q & id_fifo_empty`.

Error flags clear only on reset.

## Timing

- Reset (`ap_rst_n` = 0 at an edge): FIFO and buffer flushed, `occ` = 0, all pointers 0.
  - Outputs after reset: `cache_resp_ready`=0, `mem_resp_valid`=0, `mem_resp_data`=0, `outstanding_count`=0, `id_fifo_full`=0, `id_fifo_empty`=1, both errors 0.
  - Reset mid-operation discards all in-flight IDs and data with no partial delivery.
- `ready_q` rises at the first edge with `ap_rst_n`=1.
- Issue to count: push at edge t; `outstanding_count` and `id_fifo_empty` update after edge t. A response may be accepted from cycle t+1.
- Response latency: accept at edge t with an empty buffer gives `mem_resp_valid` high in cycle t+1. Latency is 1 cycle; throughput is 1 per cycle when requestors keep ready high.
- Buffer full (`occ`=2) with no drain: `cache_resp_ready` low from the next cycle.
- A drain restores ready one cycle later.

## Configuration

- `GLAY_RESP_ROUTER_ERROR_CHECK_EN` defined: overflow and orphan detection logic and sticky flags are built.
- Not defined: `issue_overflow_error` and `resp_orphan_error` are tied to 0 and the detection logic is removed. Drop behaviour on overflow and orphan is unchanged.

## Test plan

- Reset then idle: all outputs at reset values, `cache_resp_ready`=0 while `id_fifo_empty`=1. Issue ID 1 → `outstanding_count`=1 and `cache_resp_ready`=1 next cycle.
- Issue IDs 0,1,0 back-to-back, then return data 0xA,0xB,0xC on consecutive cycles with all ready high → `mem_resp_valid` = 01,10,01 carrying 0xA,0xB,0xC in cycles t+1..t+3; `outstanding_count` returns to 0.
- Issue 0,1; hold `mem_resp_ready`=00; return 2 responses → `occ`=2 and `cache_resp_ready` drops. Raise bit 1 only → no drain. Raise bit 0 → 0xA delivered, then 0xB on requestor 1.
- Fill FIFO with 16 issues → `id_fifo_full`=1. 17th issue alone → `issue_overflow_error`=1 and count stays 16. A 17th issue in the same cycle as a response accept → no error, count stays 16.
- Force `cache_resp_valid` with an empty FIFO → `resp_orphan_error`=1 and no `mem_resp_valid` asserted. Rerun without the macro → flag stays 0.
- Assert reset with 2 buffered responses and 3 outstanding IDs → next cycle `mem_resp_valid`=0, count 0, errors cleared.

Source files
------------

// File: rtl/cache_response_router.sv
// Routes in-order cache read responses back to the issuing requestor.
// Define GLAY_RESP_ROUTER_ERROR_CHECK_EN to build overflow/orphan flags.
module cache_response_router #(
  parameter int NUM_MEMORY_REQUESTOR = 2,
  parameter int ID_WIDTH =
    (NUM_MEMORY_REQUESTOR > 1) ?
    $clog2(NUM_MEMORY_REQUESTOR) : 1,
  parameter int DATA_WIDTH = 512,
  parameter int ID_FIFO_DEPTH = 16,
  parameter int COUNT_WIDTH =
    $clog2(ID_FIFO_DEPTH + 1)
) (
  input  logic ap_clk,
  input  logic ap_rst_n,
  input  logic req_issue_valid,
  input  logic [ID_WIDTH-1:0] req_issue_id,
  input  logic cache_resp_valid,
  input  logic [DATA_WIDTH-1:0] cache_resp_rdata,
  output logic cache_resp_ready,
  output logic [NUM_MEMORY_REQUESTOR-1:0] mem_resp_valid,
  output logic [DATA_WIDTH-1:0] mem_resp_data,
  input  logic [NUM_MEMORY_REQUESTOR-1:0] mem_resp_ready,
  output logic [COUNT_WIDTH-1:0] outstanding_count,
  output logic id_fifo_full,
  output logic id_fifo_empty,
  output logic issue_overflow_error,
  output logic resp_orphan_error
);

  localparam int PTR_W =
    (ID_FIFO_DEPTH > 1) ? $clog2(ID_FIFO_DEPTH) : 1;
  localparam logic [COUNT_WIDTH-1:0] FULL_CNT =
    COUNT_WIDTH'(ID_FIFO_DEPTH);

  logic [ID_WIDTH-1:0] id_mem [ID_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [COUNT_WIDTH-1:0] count_q;
  logic [COUNT_WIDTH-1:0] count_next;
  logic full_q;
  logic empty_q;
  logic [ID_WIDTH-1:0] head_id;

  logic [ID_WIDTH-1:0] buf_id [2];
  logic [DATA_WIDTH-1:0] buf_data [2];
  logic hd;
  logic tail;
  logic [1:0] occ;
  logic [1:0] occ_next;
  logic ready_q;

  logic accept;
  logic push;
  logic drain;

  assign cache_resp_ready = ready_q & ~empty_q;
  assign accept = cache_resp_valid & cache_resp_ready;
  // A same-cycle pop frees the slot, so a push into a full FIFO is legal.
  assign push = req_issue_valid & (~full_q | accept);
  assign head_id = id_mem[rd_ptr];

  always_comb begin
    count_next = count_q
               + COUNT_WIDTH'(push)
               - COUNT_WIDTH'(accept);
  end

  always_ff @(posedge ap_clk) begin
    if (push) id_mem[wr_ptr] <= req_issue_id;
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count_q <= '0;
      full_q <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (accept) rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_next;
      full_q <= (count_next == FULL_CNT);
      empty_q <= (count_next == '0);
    end
  end

  assign outstanding_count = count_q;
  assign id_fifo_full = full_q;
  assign id_fifo_empty = empty_q;

  assign tail = hd ^ occ[0];
  assign mem_resp_data = buf_data[hd];

  always_comb begin
    mem_resp_valid = '0;
    for (int i = 0; i < NUM_MEMORY_REQUESTOR; i++) begin
      if (occ != 2'd0 && buf_id[hd] == ID_WIDTH'(i))
        mem_resp_valid[i] = 1'b1;
    end
  end

  // Only the head's own requestor can drain it.
  assign drain = |(mem_resp_valid & mem_resp_ready);

  always_comb begin
    occ_next = occ + 2'(accept) - 2'(drain);
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      hd <= 1'b0;
      occ <= 2'd0;
      ready_q <= 1'b0;
      buf_id[0] <= '0;
      buf_id[1] <= '0;
      buf_data[0] <= '0;
      buf_data[1] <= '0;
    end else begin
      if (accept) begin
        buf_id[tail] <= head_id;
        buf_data[tail] <= cache_resp_rdata;
      end
      if (drain) hd <= ~hd;
      occ <= occ_next;
      ready_q <= (occ_next < 2'd2);
    end
  end

`ifdef GLAY_RESP_ROUTER_ERROR_CHECK_EN
  logic overflow_hit;
  logic orphan_hit;
  logic overflow_q;
  logic orphan_q;

  assign overflow_hit = req_issue_valid & full_q & ~accept;
  assign orphan_hit = cache_resp_valid & ready_q & empty_q;

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      overflow_q <= 1'b0;
      orphan_q <= 1'b0;
    end else begin
      if (overflow_hit) overflow_q <= 1'b1;
      if (orphan_hit) orphan_q <= 1'b1;
    end
  end

  assign issue_overflow_error = overflow_q;
  assign resp_orphan_error = orphan_q;
`else
  assign issue_overflow_error = 1'b0;
  assign resp_orphan_error = 1'b0;
`endif

endmodule
